net_packet_rx: RTL and testbench
================================

# net_packet_rx

Network-side packet receiver and loader for one core. Decodes `net_packet_s` packets arriving on the core's network input and turns them into the register-file, instruction-memory, barrier-mask and PC writes that boot and control the core. It sits between the network input port and the core datapath; it is the consuming end of the packet stream a boot source (bench or upstream tile) emits.

## Interface
- `core_id_p`, 10'd1: the packet `ID` this receiver accepts.
- `imem_addr_width_p`, 10: instruction-memory address width.
- `instr_width_p`, 16: instruction word width. Equals opcode(5) + `rd_size_gp` + `rs_imm_size_gp`.
- `rf_addr_width_p`, `rs_imm_size_gp`: register-file address width.
- `cnt_width_p`, 16: width of the status counters.

Ports:
- `clk`  in  1  system clock; all logic is posedge.
- `reset`  in  1  asynchronous, active-low reset.
- `net_packet_flat_i`  in  `$bits(net_packet_s)`  incoming packet, sampled every posedge.
- `imem_wen_o`  out  1  one-cycle instruction write strobe.
- `imem_addr_o`  out  `imem_addr_width_p`  instruction write address.
- `imem_data_o`  out  `instr_width_p`  instruction write data.
- `rf_wen_o`  out  1  one-cycle register write strobe.
- `rf_addr_o`  out  `rf_addr_width_p`  register write address.
- `rf_data_o`  out  32  register write data.
- `barrier_mask_o`  out  `mask_length_gp`  held barrier mask.
- `pc_wen_o`  out  1  one-cycle PC load strobe.
- `pc_o`  out  `imem_addr_width_p`  PC load value.
- `run_o`  out  1  core enabled; high in RUN.
- `err_o`  out  1  sticky protocol error.
- `instr_count_o`  out  `cnt_width_p`  accepted INSTR packets, saturating.
- `reg_count_o`  out  `cnt_width_p`  accepted REG packets, saturating.

## Operation
- A packet is **addressed** when `ID == core_id_p` and `net_op != NULL`. Unaddressed packets cause no state change, strobe or error.
- FSM states: `RX_LOAD` (reset state) and `RX_RUN`.
  - `RX_LOAD` → `RX_RUN` on an accepted PC packet.
  - `RX_RUN` never returns to `RX_LOAD` except by reset.
- **INSTR**
  - In `RX_LOAD`: `imem_addr_o = net_addr[imem_addr_width_p-1:0]`, `imem_data_o = net_data[instr_width_p-1:0]`, `imem_wen_o` pulses, `instr_count_o` increments. Upper `net_data` bits are ignored.
  - In `RX_RUN`: dropped, no strobe, `err_o` set.
- **REG**, accepted in both states:
  - `rf_addr_o = net_addr[rf_addr_width_p-1:0]`, `rf_data_o = net_data`, `rf_wen_o` pulses, `reg_count_o` increments.
  - If `net_addr[9:rf_addr_width_p]` is nonzero: dropped, `err_o` set.
- **BAR**, both states: `barrier_mask_o <= net_data[mask_length_gp-1:0]`. `net_addr` is ignored.
- **PC**, both states: `pc_o = net_data[imem_addr_width_p-1:0]`, `pc_wen_o` pulses, state becomes `RX_RUN`. A PC packet while already in `RX_RUN` re-issues the pulse, which acts as a restart.
- Any other addressed `net_op` encoding sets `err_o`. No other effect.
- Counters saturate at all-ones and do not wrap. Only reset clears them.
- `err_o` is sticky until reset.

## Timing
- Every output is a flop.
- Latency: a packet sampled at posedge N produces its strobes and data on the outputs after posedge N+1, so they are visible for the cycle N+1..N+2.
- Each strobe is high for exactly one cycle per accepted packet.
- Back-to-back accepted packets produce back-to-back strobes with no bubbles.
- `run_o` rises in the same cycle as the first `pc_wen_o`.
- Strobe outputs (`imem_wen_o`, `rf_wen_o`, `pc_wen_o`) drop to 0 on any cycle without a matching accepted packet. The data/address outputs hold their last value.
- Reset asserted at any time, including mid-load or in `RX_RUN`: all outputs go to 0 immediately and asynchronously, and the state returns to `RX_LOAD`. After deassertion, the first packet is sampled on the next posedge.
- Only one packet arrives per cycle, so no two ops can conflict.

## Structure
- `net_packet_s`, `net_op_e`, `mask_length_gp`, `rd_size_gp` and `rs_imm_size_gp` stay in the shared definitions package.
- Add `rx_state_e {RX_LOAD, RX_RUN}` to the same package.
- One sub-module: `sat_counter #(width_p)`, with increment enable and async active-low reset. It is instantiated twice.
- The decode and FSM live in `net_packet_rx`.

## Test plan
- **Reset values:** hold `reset`=0, then release. All outputs are 0, `run_o`=0, and an all-NULL packet stream produces no strobes for 10 cycles.
- **Instruction load:** 3 INSTR packets, ID 1, addrs 0/1/2, data 16'h0841/16'h1082/16'hFFFF, sent back to back. Expect three consecutive `imem_wen_o` pulses, each one cycle after its packet, with matching addr/data, and `instr_count_o`=3.
- **ID filter and REG range:**
  - REG packet with ID 2, addr 5 → no `rf_wen_o`.
  - REG with ID 1, addr 10'd70 → no write, `err_o`=1.
  - REG with ID 1, addr 5, data 32'hDEADBEEF → `rf_wen_o` pulse with `rf_addr_o`=5 and `rf_data_o`=32'hDEADBEEF.
- **BAR then PC:**
  - BAR with data 32'h2 → `barrier_mask_o`=2, held.
  - PC with data 5 → `pc_wen_o` pulse, `pc_o`=5, `run_o`=1 in the same cycle.
- **Run-state rules:**
  - In `RX_RUN`, an INSTR to addr 3 → no `imem_wen_o`, `err_o`=1, `instr_count_o` unchanged.
  - A REG write still succeeds.
  - A second PC packet with data 0 → `pc_wen_o` pulse, `pc_o`=0.
- **Async reset mid-run:** assert `reset` between clock edges in `RX_RUN` with `barrier_mask_o`=2. All outputs are 0 before the next posedge. A subsequent INSTR is accepted, confirming `RX_LOAD`.

Source files
------------

// File: rtl/net_packet_rx_pkg.sv
// Shared network packet definitions: packet layout, opcodes and receiver FSM states.
package net_packet_rx_pkg;

    localparam int mask_length_gp    = 8;
    localparam int rd_size_gp        = 5;
    localparam int rs_imm_size_gp    = 6;
    localparam int net_id_width_gp   = 10;
    localparam int net_addr_width_gp = 10;
    localparam int net_data_width_gp = 32;

    typedef enum logic [2:0] {
        NULL  = 3'd0,
        INSTR = 3'd1,
        REG   = 3'd2,
        PC    = 3'd3,
        BAR   = 3'd4
    } net_op_e;

    typedef struct packed {
        logic [net_id_width_gp-1:0]   ID;
        net_op_e                      net_op;
        logic [net_addr_width_gp-1:0] net_addr;
        logic [net_data_width_gp-1:0] net_data;
    } net_packet_s;

    typedef enum logic {
        RX_LOAD = 1'b0,
        RX_RUN  = 1'b1
    } rx_state_e;

endpackage

// File: rtl/net_packet_rx_if.sv
// Packet input and core-facing write/status signals of the network receiver.
interface net_packet_rx_if
    import net_packet_rx_pkg::*;
#(
    parameter int imem_addr_width_p = 10,
    parameter int instr_width_p     = 16,
    parameter int rf_addr_width_p   = rs_imm_size_gp,
    parameter int cnt_width_p       = 16
);

    logic [$bits(net_packet_s)-1:0] net_packet_flat_i;
    logic                           imem_wen_o;
    logic [imem_addr_width_p-1:0]   imem_addr_o;
    logic [instr_width_p-1:0]       imem_data_o;
    logic                           rf_wen_o;
    logic [rf_addr_width_p-1:0]     rf_addr_o;
    logic [31:0]                    rf_data_o;
    logic [mask_length_gp-1:0]      barrier_mask_o;
    logic                           pc_wen_o;
    logic [imem_addr_width_p-1:0]   pc_o;
    logic                           run_o;
    logic                           err_o;
    logic [cnt_width_p-1:0]         instr_count_o;
    logic [cnt_width_p-1:0]         reg_count_o;

    // The receiver side: consumes packets, drives the core writes.
    modport master (
        input  net_packet_flat_i,
        output imem_wen_o, imem_addr_o, imem_data_o,
        output rf_wen_o, rf_addr_o, rf_data_o,
        output barrier_mask_o, pc_wen_o, pc_o, run_o, err_o,
        output instr_count_o, reg_count_o
    );

    modport slave (
        output net_packet_flat_i,
        input  imem_wen_o, imem_addr_o, imem_data_o,
        input  rf_wen_o, rf_addr_o, rf_data_o,
        input  barrier_mask_o, pc_wen_o, pc_o, run_o, err_o,
        input  instr_count_o, reg_count_o
    );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int width_p = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inc_i,
    output logic [width_p-1:0] count_o
);

    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_o <= '0;
        end else if (inc_i && (count_o != '1)) begin
            count_o <= count_o + width_p'(1);
        end
    end

endmodule

// File: rtl/net_packet_rx.sv
// Network packet receiver: registers each packet, decodes it and issues registered
// instruction/register/barrier/PC writes two edges after the packet is presented.
module net_packet_rx
    import net_packet_rx_pkg::*;
#(
    parameter logic [net_id_width_gp-1:0] core_id_p = 10'd1,
    parameter int imem_addr_width_p = 10,
    parameter int instr_width_p     = 16,
    parameter int rf_addr_width_p   = rs_imm_size_gp,
    parameter int cnt_width_p       = 16
) (
    input  logic            clk,
    input  logic            reset,
    net_packet_rx_if.master rx
);

    net_packet_s                  pkt_q;
    rx_state_e                    state_q, state_n;
    logic                         addressed;

    logic                         imem_wen_n, rf_wen_n, pc_wen_n, err_n;
    logic [imem_addr_width_p-1:0] imem_addr_n, pc_n;
    logic [instr_width_p-1:0]     imem_data_n;
    logic [rf_addr_width_p-1:0]   rf_addr_n;
    logic [31:0]                  rf_data_n;
    logic [mask_length_gp-1:0]    mask_n;
    logic                         instr_inc, reg_inc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pkt_q   <= '0;
            state_q <= RX_LOAD;
        end else begin
            pkt_q   <= net_packet_s'(rx.net_packet_flat_i);
            state_q <= state_n;
        end
    end

    assign addressed = (pkt_q.ID == core_id_p) && (pkt_q.net_op != NULL);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_n     = state_q;
        imem_wen_n  = 1'b0;
        rf_wen_n    = 1'b0;
        pc_wen_n    = 1'b0;
        imem_addr_n = rx.imem_addr_o;
        imem_data_n = rx.imem_data_o;
        rf_addr_n   = rx.rf_addr_o;
        rf_data_n   = rx.rf_data_o;
        pc_n        = rx.pc_o;
        mask_n      = rx.barrier_mask_o;
        err_n       = rx.err_o;
        instr_inc   = 1'b0;
        reg_inc     = 1'b0;

        if (addressed) begin
            case (pkt_q.net_op)
                INSTR: begin
                    if (state_q == RX_LOAD) begin
                        imem_wen_n  = 1'b1;
                        imem_addr_n = pkt_q.net_addr[imem_addr_width_p-1:0];
                        imem_data_n = pkt_q.net_data[instr_width_p-1:0];
                        instr_inc   = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                end
                REG: begin
                    if (|pkt_q.net_addr[net_addr_width_gp-1:rf_addr_width_p]) begin
                        err_n = 1'b1;
                    end else begin
                        rf_wen_n  = 1'b1;
                        rf_addr_n = pkt_q.net_addr[rf_addr_width_p-1:0];
                        rf_data_n = pkt_q.net_data;
                        reg_inc   = 1'b1;
                    end
                end
                BAR: mask_n = pkt_q.net_data[mask_length_gp-1:0];
                PC: begin
                    pc_wen_n = 1'b1;
                    pc_n     = pkt_q.net_data[imem_addr_width_p-1:0];
                    state_n  = RX_RUN;
                end
                default: err_n = 1'b1;
            endcase
        end
    end

    // run_o is its own flop loaded from state_n so it rises with the first pc_wen_o.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx.imem_wen_o     <= 1'b0;
            rx.imem_addr_o    <= '0;
            rx.imem_data_o    <= '0;
            rx.rf_wen_o       <= 1'b0;
            rx.rf_addr_o      <= '0;
            rx.rf_data_o      <= '0;
            rx.barrier_mask_o <= '0;
            rx.pc_wen_o       <= 1'b0;
            rx.pc_o           <= '0;
            rx.run_o          <= 1'b0;
            rx.err_o          <= 1'b0;
        end else begin
            rx.imem_wen_o     <= imem_wen_n;
            rx.imem_addr_o    <= imem_addr_n;
            rx.imem_data_o    <= imem_data_n;
            rx.rf_wen_o       <= rf_wen_n;
            rx.rf_addr_o      <= rf_addr_n;
            rx.rf_data_o      <= rf_data_n;
            rx.barrier_mask_o <= mask_n;
            rx.pc_wen_o       <= pc_wen_n;
            rx.pc_o           <= pc_n;
            rx.run_o          <= (state_n == RX_RUN);
            rx.err_o          <= err_n;
        end
    end

    sat_counter #(.width_p(cnt_width_p)) u_instr_count (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (instr_inc),
        .count_o (rx.instr_count_o)
    );

    sat_counter #(.width_p(cnt_width_p)) u_reg_count (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (reg_inc),
        .count_o (rx.reg_count_o)
    );

endmodule

// File: tb/tb_net_packet_rx.sv
// Scoreboard bench for net_packet_rx: the driver queues expected write strobes,
// a negedge monitor pops and compares them; status outputs are checked directly.
module tb_net_packet_rx;
    import net_packet_rx_pkg::*;

    typedef enum {K_IMEM, K_RF, K_PC} kind_e;
    typedef struct {
        kind_e       kind;
        int          due;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   fails;
    exp_t sb[$];

    net_packet_rx_if rx_if ();

    net_packet_rx dut (
        .clk   (clk),
        .reset (reset),
        .rx    (rx_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one packet for one cycle; the write it causes is due two edges later.
    task automatic send(input logic [9:0] id, input net_op_e op, input logic [9:0] addr,
                        input logic [31:0] data);
        net_packet_s p;
        @(negedge clk);
        p.ID = id; p.net_op = op; p.net_addr = addr; p.net_data = data;
        rx_if.net_packet_flat_i = p;
    endtask

    task automatic expect_wr(input kind_e kind, input logic [31:0] addr, input logic [31:0] data);
        exp_t e;
        e.kind = kind; e.due = cyc + 2; e.addr = addr; e.data = data;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_if.net_packet_flat_i = '0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_imem_wen"},  rx_if.imem_wen_o, 0);
        check({tag, "_imem_addr"}, rx_if.imem_addr_o, 0);
        check({tag, "_imem_data"}, rx_if.imem_data_o, 0);
        check({tag, "_rf_wen"},    rx_if.rf_wen_o, 0);
        check({tag, "_rf_addr"},   rx_if.rf_addr_o, 0);
        check({tag, "_rf_data"},   rx_if.rf_data_o, 0);
        check({tag, "_mask"},      rx_if.barrier_mask_o, 0);
        check({tag, "_pc_wen"},    rx_if.pc_wen_o, 0);
        check({tag, "_pc"},        rx_if.pc_o, 0);
        check({tag, "_run"},       rx_if.run_o, 0);
        check({tag, "_err"},       rx_if.err_o, 0);
        check({tag, "_instr_cnt"}, rx_if.instr_count_o, 0);
        check({tag, "_reg_cnt"},   rx_if.reg_count_o, 0);
    endtask

    // Monitor: any strobe must match the head of the scoreboard in kind, cycle and payload.
    always @(negedge clk) begin
        int   n;
        exp_t e;
        if (reset) begin
            n = int'(rx_if.imem_wen_o) + int'(rx_if.rf_wen_o) + int'(rx_if.pc_wen_o);
            if (n != 0) begin
                check("one_strobe_per_cycle", n, 1);
                check("strobe_was_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("strobe_cycle", cyc, e.due);
                    case (e.kind)
                        K_IMEM: begin
                            check("imem_wen", rx_if.imem_wen_o, 1);
                            check("imem_addr", rx_if.imem_addr_o, e.addr);
                            check("imem_data", rx_if.imem_data_o, e.data);
                        end
                        K_RF: begin
                            check("rf_wen", rx_if.rf_wen_o, 1);
                            check("rf_addr", rx_if.rf_addr_o, e.addr);
                            check("rf_data", rx_if.rf_data_o, e.data);
                        end
                        default: begin
                            check("pc_wen", rx_if.pc_wen_o, 1);
                            check("pc", rx_if.pc_o, e.data);
                            check("run_with_pc", rx_if.run_o, 1);
                        end
                    endcase
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        fails  = 0;
        reset  = 1'b0;
        rx_if.net_packet_flat_i = '0;

        // Reset values, then a quiet NULL stream.
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;
        idle(10);
        check("quiet_run", rx_if.run_o, 0);
        check("quiet_instr_cnt", rx_if.instr_count_o, 0);

        // Back-to-back instruction load; upper data bits of the first are ignored.
        send(10'd1, INSTR, 10'd0, 32'h5A5A_0841); expect_wr(K_IMEM, 0, 32'h0841);
        send(10'd1, INSTR, 10'd1, 32'h0000_1082); expect_wr(K_IMEM, 1, 32'h1082);
        send(10'd1, INSTR, 10'd2, 32'h0000_FFFF); expect_wr(K_IMEM, 2, 32'hFFFF);
        idle(3);
        check("instr_cnt_3", rx_if.instr_count_o, 3);
        check("load_run_low", rx_if.run_o, 0);

        // ID filter, REG range check, then a good REG write.
        send(10'd2, REG, 10'd5, 32'h1111_1111);
        idle(3);
        check("other_id_no_err", rx_if.err_o, 0);
        check("other_id_reg_cnt", rx_if.reg_count_o, 0);
        send(10'd1, REG, 10'd70, 32'h2222_2222);
        idle(3);
        check("reg_range_err", rx_if.err_o, 1);
        check("reg_range_cnt", rx_if.reg_count_o, 0);
        send(10'd1, REG, 10'd5, 32'hDEAD_BEEF); expect_wr(K_RF, 5, 32'hDEAD_BEEF);
        idle(3);
        check("reg_cnt_1", rx_if.reg_count_o, 1);

        // Barrier mask then PC load into RX_RUN.
        send(10'd1, BAR, 10'd3, 32'h0000_0002);
        idle(3);
        check("bar_mask", rx_if.barrier_mask_o, 2);
        check("pre_pc_run", rx_if.run_o, 0);
        send(10'd1, PC, 10'd0, 32'h0000_0005); expect_wr(K_PC, 0, 5);
        idle(3);
        check("run_after_pc", rx_if.run_o, 1);
        check("mask_held", rx_if.barrier_mask_o, 2);

        // Run-state rules: INSTR rejected, REG accepted, PC restarts.
        send(10'd1, INSTR, 10'd3, 32'h0000_1234);
        idle(3);
        check("run_instr_err", rx_if.err_o, 1);
        check("run_instr_cnt", rx_if.instr_count_o, 3);
        check("run_imem_addr_held", rx_if.imem_addr_o, 2);
        send(10'd1, REG, 10'd7, 32'h1234_5678); expect_wr(K_RF, 7, 32'h1234_5678);
        send(10'd1, PC, 10'd0, 32'h0000_0000); expect_wr(K_PC, 0, 0);
        idle(3);
        check("run_reg_cnt", rx_if.reg_count_o, 2);
        check("run_still", rx_if.run_o, 1);

        // Asynchronous reset between clock edges while running.
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        reset = 1'b1;
        send(10'd1, INSTR, 10'd4, 32'h0000_0ABC); expect_wr(K_IMEM, 4, 32'h0ABC);
        idle(3);
        check("post_reset_instr_cnt", rx_if.instr_count_o, 1);
        check("post_reset_run", rx_if.run_o, 0);
        check("post_reset_err", rx_if.err_o, 0);

        // Unknown opcode only raises the sticky error.
        send(10'd1, net_op_e'(3'd7), 10'd0, 32'hFFFF_FFFF);
        idle(3);
        check("bad_op_err", rx_if.err_o, 1);
        check("bad_op_mask", rx_if.barrier_mask_o, 0);

        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
